// File: rtl/lcd_scan_gen_if.sv
// Pixel-source handshake and LCD panel pins of the scan generator.
// The slave side is the scan generator; the master side is the renderer/board.
interface lcd_scan_gen_if #(
    parameter int BPP  = 2,
    parameter int HPIX = 160,
    parameter int VTOT = 171
);
    localparam int FXW = $clog2(HPIX + 1);
    localparam int FYW = $clog2(VTOT);

    logic           en;
    logic [BPP-1:0] pix_data;
    logic           pix_valid;
    logic           pix_ready;
    logic [FXW-1:0] fetch_x;
    logic [FYW-1:0] fetch_y;
    logic [BPP-1:0] d;
    logic           hsync;
    logic           vsync;
    logic           datal;
    logic           altsig;
    logic           clk;
    logic           control;
    logic           underrun;
    logic           underrun_clr;

    modport master (
        output en, pix_data, pix_valid, underrun_clr,
        input  pix_ready, fetch_x, fetch_y, d, hsync, vsync,
        input  datal, altsig, clk, control, underrun
    );

    modport slave (
        input  en, pix_data, pix_valid, underrun_clr,
        output pix_ready, fetch_x, fetch_y, d, hsync, vsync,
        output datal, altsig, clk, control, underrun
    );
endinterface

// File: rtl/lcd_scan_gen.sv
// LCD scan generator: counters, line pixel FIFO and registered panel pins.
// Starts/stops only on frame boundaries; every pin lags its state by 1 cycle.
module lcd_scan_gen #(
    parameter int HTOT        = 501,
    parameter int VTOT        = 171,
    parameter int HPIX_START  = 80,
    parameter int HPIX        = 160,
    parameter int VPIX        = 160,
    parameter int HSYNC_START = 62,
    parameter int HSYNC_END   = 78,
    parameter int HSYNC_CLK   = 70,
    parameter int DLAT_START  = 485,
    parameter int DLAT_END    = 501,
    parameter int CLK_DIV     = 2,
    parameter int BPP         = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input logic            clk_8m,
    input logic            rst,
    lcd_scan_gen_if.slave  bus
);
    localparam int PW  = $clog2(CLK_DIV);
    localparam int XW  = $clog2(HTOT);
    localparam int YW  = $clog2(VTOT);
    localparam int FXW = $clog2(HPIX + 1);
    localparam int AW  = $clog2(FIFO_DEPTH);

    logic           running_q, running_d;
    logic [PW-1:0]  phase_q, phase_d;
    logic [XW-1:0]  xpos_q, xpos_d;
    logic [YW-1:0]  ypos_q, ypos_d;
    logic           alt_q, alt_d;

    logic [BPP-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]  wp_q, rp_q;
    logic [AW:0]    cnt_q;
    logic [FXW-1:0] fx_q;
    logic [YW-1:0]  fy_q;
    logic [BPP-1:0] cur_q;
    logic           urun_q;

    logic [BPP-1:0] d_q, d_d;
    logic           hs_q, hs_d, vs_q, vs_d, dl_q, dl_d;
    logic           ck_q, ck_d, ct_q, ct_d, as_q, as_d;

    int   xi, yi, pi;
    logic tick, eol, eof, act, nx_act;
    logic full, empty, ready, push, pop;

    assign xi = int'(xpos_q);
    assign yi = int'(ypos_q);
    assign pi = int'(phase_q);

    assign tick   = running_q && (pi == CLK_DIV - 1);
    assign eol    = tick && (xi == HTOT - 1);
    assign eof    = eol && (yi == VTOT - 1);
    assign act    = (yi < VPIX) && (xi >= HPIX_START) && (xi < HPIX_START + HPIX);
    assign nx_act = tick && !eol && (yi < VPIX)
                  && (xi + 1 >= HPIX_START) && (xi + 1 < HPIX_START + HPIX);

    assign full  = int'(cnt_q) == FIFO_DEPTH;
    assign empty = cnt_q == '0;
    assign ready = running_q && !full && (int'(fx_q) < HPIX) && (int'(fy_q) < VPIX);
    assign push  = bus.pix_valid && ready && !eol;
    assign pop   = nx_act && !empty;

    // Next scan position; en is only honoured at the frame boundary when stopping.
    always_comb begin
        running_d = running_q;
        phase_d   = phase_q;
        xpos_d    = xpos_q;
        ypos_d    = ypos_q;
        alt_d     = alt_q;
        if (!running_q) begin
            running_d = bus.en;
        end else begin
            phase_d = (pi == CLK_DIV - 1) ? '0 : phase_q + 1'b1;
            if (eol) begin
                xpos_d = '0;
                if (eof) begin
                    ypos_d = '0;
                    alt_d  = ~alt_q;
                    if (!bus.en) begin
                        running_d = 1'b0;
                        alt_d     = 1'b0;
                    end
                end else begin
                    ypos_d = ypos_q + 1'b1;
                end
            end else if (tick) begin
                xpos_d = xpos_q + 1'b1;
            end
        end
    end

    // Scan state registers.
    always_ff @(posedge clk_8m or posedge rst) begin
        if (rst) begin
            running_q <= 1'b0;
            phase_q   <= '0;
            xpos_q    <= '0;
            ypos_q    <= '0;
            alt_q     <= 1'b0;
        end else begin
            running_q <= running_d;
            phase_q   <= phase_d;
            xpos_q    <= xpos_d;
            ypos_q    <= ypos_d;
            alt_q     <= alt_d;
        end
    end

    // FIFO storage; stale entries are harmless since pointers gate them.
    always_ff @(posedge clk_8m) begin
        if (push) begin
            mem_q[wp_q] <= bus.pix_data;
        end
    end

    // FIFO control, fetch cursor, per-slot pixel latch and sticky underrun.
    always_ff @(posedge clk_8m or posedge rst) begin
        if (rst) begin
            wp_q   <= '0;
            rp_q   <= '0;
            cnt_q  <= '0;
            fx_q   <= '0;
            fy_q   <= '0;
            cur_q  <= '1;
            urun_q <= 1'b0;
        end else begin
            if (eol) begin
                wp_q  <= '0;
                rp_q  <= '0;
                cnt_q <= '0;
                fx_q  <= '0;
                fy_q  <= ypos_d;
            end else begin
                if (push) begin
                    wp_q <= wp_q + 1'b1;
                    fx_q <= fx_q + 1'b1;
                end
                if (pop) begin
                    rp_q <= rp_q + 1'b1;
                end
                if (push && !pop) begin
                    cnt_q <= cnt_q + 1'b1;
                end else if (pop && !push) begin
                    cnt_q <= cnt_q - 1'b1;
                end
            end
            if (nx_act) begin
                cur_q <= empty ? '1 : ~mem_q[rp_q];
            end
            if (nx_act && empty) begin
                urun_q <= 1'b1;
            end else if (bus.underrun_clr) begin
                urun_q <= 1'b0;
            end
        end
    end

    // Decode of the current scan position into the next pin values.
    always_comb begin
        d_d  = '1;
        hs_d = 1'b0;
        vs_d = 1'b0;
        dl_d = 1'b0;
        ck_d = 1'b0;
        ct_d = 1'b0;
        as_d = 1'b0;
        if (running_q) begin
            vs_d = (yi == 0);
            hs_d = (xi >= HSYNC_START) && (xi < HSYNC_END);
            dl_d = (xi >= DLAT_START) && (xi < DLAT_END);
            ct_d = (xi < 10) || (xi >= 31 && xi <= 34)
                || (xi >= 181 && xi <= 184) || (xi >= 321 && xi <= 325)
                || (xi >= DLAT_START);
            ck_d = (act && (pi < CLK_DIV / 2))
                || (xi == HSYNC_CLK) || (xi == HSYNC_CLK + 1);
            d_d  = act ? cur_q : '1;
            as_d = alt_q;
        end
    end

    // Panel pin registers.
    always_ff @(posedge clk_8m or posedge rst) begin
        if (rst) begin
            d_q  <= '1;
            hs_q <= 1'b0;
            vs_q <= 1'b0;
            dl_q <= 1'b0;
            ck_q <= 1'b0;
            ct_q <= 1'b0;
            as_q <= 1'b0;
        end else begin
            d_q  <= d_d;
            hs_q <= hs_d;
            vs_q <= vs_d;
            dl_q <= dl_d;
            ck_q <= ck_d;
            ct_q <= ct_d;
            as_q <= as_d;
        end
    end

    assign bus.pix_ready = ready;
    assign bus.fetch_x   = fx_q;
    assign bus.fetch_y   = fy_q;
    assign bus.d         = d_q;
    assign bus.hsync     = hs_q;
    assign bus.vsync     = vs_q;
    assign bus.datal     = dl_q;
    assign bus.altsig    = as_q;
    assign bus.clk       = ck_q;
    assign bus.control   = ct_q;
    assign bus.underrun  = urun_q;
endmodule
